// File: rtl/limit_pkg.sv
// Shared types for the limit manager: requested-mode encodings, FSM states
// and the slot-index width helper used to size the slot ports.
package limit_pkg;

    typedef enum logic [1:0] {
        MODE_SINGLE = 2'd0,
        MODE_CARRY  = 2'd1,
        MODE_MAX    = 2'd2,
        MODE_HOLD   = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_SINGLE = 2'd0,
        ST_CARRY  = 2'd1,
        ST_MAX    = 2'd2
    } state_e;

    // A one-slot bank still needs a one-bit index port.
    function automatic int slotWidth(input int slots);
        return (slots > 1) ? $clog2(slots) : 1;
    endfunction

endpackage

// File: rtl/limit_bank.sv
// Limit slot storage with BCD clamping on write, the active-slot register and
// a look-ahead read of the active limit as it will be after the coming edge.
module limit_bank
    import limit_pkg::*;
#(
    parameter int DIGITS = 6,
    parameter int SLOTS  = 4,
    localparam int SW    = slotWidth(SLOTS),
    localparam int W     = 4 * DIGITS
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic [W-1:0]  cnt_i,
    input  logic          store_i,
    input  logic [SW-1:0] wrSel_i,
    input  logic          actLoad_i,
    input  logic [SW-1:0] actSel_i,
    output logic [SW-1:0] activeSlot_o,
    output logic [W-1:0]  nextLimit_o,
    output logic          idxErr_o
);

    logic [W-1:0]  slots_q [SLOTS];
    logic [SW-1:0] activeSlot_q;
    logic [SW-1:0] activeSlot_d;
    logic [W-1:0]  cntClamped;
    logic          wrValid;
    logic          actValid;
    logic          doStore;

    function automatic logic [W-1:0] clampBcd(input logic [W-1:0] value);
        logic [W-1:0] result;
        result = '0;
        for (int i = 0; i < DIGITS; i++) begin
            result[4*i +: 4] = (value[4*i +: 4] > 4'd9) ? 4'd9 : value[4*i +: 4];
        end
        return result;
    endfunction

    always_comb begin
        wrValid      = int'(wrSel_i) < SLOTS;
        actValid     = int'(actSel_i) < SLOTS;
        doStore      = store_i && wrValid;
        cntClamped   = clampBcd(cnt_i);
        activeSlot_d = (actLoad_i && actValid) ? actSel_i : activeSlot_q;
        idxErr_o     = (store_i && !wrValid) || (actLoad_i && !actValid);
        // Forward a same-edge store so the FSM sees the post-edge limit.
        if (doStore && (wrSel_i == activeSlot_d)) begin
            nextLimit_o = cntClamped;
        end else begin
            nextLimit_o = slots_q[activeSlot_d];
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int s = 0; s < SLOTS; s++) begin
                slots_q[s] <= '0;
            end
            activeSlot_q <= '0;
        end else begin
            if (doStore) begin
                slots_q[wrSel_i] <= cntClamped;
            end
            activeSlot_q <= activeSlot_d;
        end
    end

    assign activeSlot_o = activeSlot_q;

endmodule

// File: rtl/limit_manager.sv
// Limit manager top: slot bank plus the SINGLE/CARRY/MAX mode FSM, with every
// output taken straight from a register.
module limit_manager
    import limit_pkg::*;
#(
    parameter int DIGITS = 6,
    parameter int SLOTS  = 4,
    localparam int SW    = slotWidth(SLOTS),
    localparam int W     = 4 * DIGITS
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [W-1:0]  cnt_in,
    input  logic [1:0]    mode_req,
    input  logic          store,
    input  logic [SW-1:0] wr_sel,
    input  logic          act_load,
    input  logic [SW-1:0] act_sel,
    output logic [W-1:0]  max_out,
    output logic          carry_en,
    output logic          max_en,
    output logic [SW-1:0] active_slot,
    output logic          limit_err
);

    state_e       state_q, state_d;
    logic [W-1:0] maxOut_q, maxOut_d;
    logic         carryEn_q, carryEn_d;
    logic         maxEn_q, maxEn_d;
    logic         limitErr_q, limitErr_d;
    logic [W-1:0] nextLimit;
    logic         idxErr;
    logic         limitZero;
    logic         fsmErr;

    limit_bank #(
        .DIGITS (DIGITS),
        .SLOTS  (SLOTS)
    ) u_bank (
        .clk_i        (clk),
        .reset_i      (reset),
        .cnt_i        (cnt_in),
        .store_i      (store),
        .wrSel_i      (wr_sel),
        .actLoad_i    (act_load),
        .actSel_i     (act_sel),
        .activeSlot_o (active_slot),
        .nextLimit_o  (nextLimit),
        .idxErr_o     (idxErr)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_SINGLE;
            maxOut_q   <= '0;
            carryEn_q  <= 1'b0;
            maxEn_q    <= 1'b0;
            limitErr_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            maxOut_q   <= maxOut_d;
            carryEn_q  <= carryEn_d;
            maxEn_q    <= maxEn_d;
            limitErr_q <= limitErr_d;
        end
    end

    // MAX is only ever entered or held with a non-zero post-edge limit.
    always_comb begin
        state_d   = state_q;
        fsmErr    = 1'b0;
        limitZero = (nextLimit == '0);
        case (mode_e'(mode_req))
            MODE_SINGLE: state_d = ST_SINGLE;
            MODE_CARRY:  state_d = ST_CARRY;
            MODE_MAX: begin
                if (limitZero) begin
                    fsmErr  = 1'b1;
                    state_d = (state_q == ST_MAX) ? ST_SINGLE : state_q;
                end else begin
                    state_d = ST_MAX;
                end
            end
            default: begin
                if ((state_q == ST_MAX) && limitZero) begin
                    fsmErr  = 1'b1;
                    state_d = ST_SINGLE;
                end
            end
        endcase
    end

    always_comb begin
        maxOut_d   = '0;
        carryEn_d  = 1'b0;
        maxEn_d    = 1'b0;
        limitErr_d = fsmErr || idxErr;
        case (state_d)
            ST_MAX: begin
                maxEn_d  = 1'b1;
                maxOut_d = nextLimit;
            end
            ST_CARRY: begin
                carryEn_d = 1'b1;
                for (int i = 0; i < DIGITS; i++) begin
                    maxOut_d[4*i] = (nextLimit[4*i +: 4] != 4'd0);
                end
            end
            default: maxOut_d = '0;
        endcase
    end

    assign max_out  = maxOut_q;
    assign carry_en = carryEn_q;
    assign max_en   = maxEn_q;
    assign limit_err = limitErr_q;

endmodule

// File: tb/tb_limit_manager.sv
// Directed scoreboard bench for limit_manager with three slots, so that slot
// index 3 exercises the out-of-range rejection path.
module tb_limit_manager;

    localparam int DIGITS = 6;
    localparam int SLOTS  = 3;
    localparam int SW     = 2;
    localparam int W      = 4 * DIGITS;

    typedef struct {
        string         name;
        logic [W-1:0]  maxOut;
        logic          carryEn;
        logic          maxEn;
        logic [SW-1:0] slot;
        logic          err;
    } expect_t;

    logic          clock = 1'b0;
    logic          reset;
    logic [W-1:0]  cntIn;
    logic [1:0]    modeReq;
    logic          store;
    logic [SW-1:0] wrSel;
    logic          actLoad;
    logic [SW-1:0] actSel;
    logic [W-1:0]  maxOut;
    logic          carryEn;
    logic          maxEn;
    logic [SW-1:0] activeSlot;
    logic          limitErr;

    expect_t expQ[$];
    int      checks = 0;
    int      passes = 0;

    limit_manager #(
        .DIGITS (DIGITS),
        .SLOTS  (SLOTS)
    ) dut (
        .clk         (clock),
        .reset       (reset),
        .cnt_in      (cntIn),
        .mode_req    (modeReq),
        .store       (store),
        .wr_sel      (wrSel),
        .act_load    (actLoad),
        .act_sel     (actSel),
        .max_out     (maxOut),
        .carry_en    (carryEn),
        .max_en      (maxEn),
        .active_slot (activeSlot),
        .limit_err   (limitErr)
    );

    always #5 clock = ~clock;

    // Drive one edge worth of inputs and queue the outputs expected after it.
    task automatic applyStimulus(
        input string         name,
        input logic          rst,
        input logic [W-1:0]  cnt,
        input logic [1:0]    mode,
        input logic          st,
        input logic [SW-1:0] wsel,
        input logic          al,
        input logic [SW-1:0] asel,
        input logic [W-1:0]  eMax,
        input logic          eCarry,
        input logic          eMaxEn,
        input logic [SW-1:0] eSlot,
        input logic          eErr
    );
        expect_t e;
        @(negedge clock);
        reset    = rst;
        cntIn    = cnt;
        modeReq  = mode;
        store    = st;
        wrSel    = wsel;
        actLoad  = al;
        actSel   = asel;
        e.name    = name;
        e.maxOut  = eMax;
        e.carryEn = eCarry;
        e.maxEn   = eMaxEn;
        e.slot    = eSlot;
        e.err     = eErr;
        expQ.push_back(e);
        @(posedge clock);
    endtask

    task automatic checkOutput(input expect_t e);
        checks++;
        if (maxOut === e.maxOut) passes++;
        else $display("[TB] FAIL %s max_out: got %h want %h", e.name, maxOut, e.maxOut);
        checks++;
        if (carryEn === e.carryEn) passes++;
        else $display("[TB] FAIL %s carry_en: got %b want %b", e.name, carryEn, e.carryEn);
        checks++;
        if (maxEn === e.maxEn) passes++;
        else $display("[TB] FAIL %s max_en: got %b want %b", e.name, maxEn, e.maxEn);
        checks++;
        if (activeSlot === e.slot) passes++;
        else $display("[TB] FAIL %s active_slot: got %0d want %0d", e.name, activeSlot, e.slot);
        checks++;
        if (limitErr === e.err) passes++;
        else $display("[TB] FAIL %s limit_err: got %b want %b", e.name, limitErr, e.err);
    endtask

    // Monitor: outputs are registered, so each edge presents one response.
    initial begin : monitor
        expect_t e;
        forever begin
            @(posedge clock);
            #1;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput(e);
            end
        end
    end

    initial begin : stimulus
        reset   = 1'b1;
        cntIn   = '0;
        modeReq = 2'd3;
        store   = 1'b0;
        wrSel   = '0;
        actLoad = 1'b0;
        actSel  = '0;

        //            name            rst cnt         md    st wsel al asel  max         ce    me    slot  err
        applyStimulus("reset",        1, 24'h000000, 2'd3, 0, 2'd0, 0, 2'd0, 24'h000000, 1'b0, 1'b0, 2'd0, 1'b0);
        applyStimulus("idle",         0, 24'h000000, 2'd3, 0, 2'd0, 0, 2'd0, 24'h000000, 1'b0, 1'b0, 2'd0, 1'b0);
        applyStimulus("maxLoad",      0, 24'h000123, 2'd2, 1, 2'd1, 1, 2'd1, 24'h000123, 1'b0, 1'b1, 2'd1, 1'b0);
        applyStimulus("maxHold",      0, 24'h000000, 2'd3, 0, 2'd0, 0, 2'd0, 24'h000123, 1'b0, 1'b1, 2'd1, 1'b0);
        applyStimulus("carryMask",    0, 24'h010203, 2'd1, 1, 2'd1, 0, 2'd0, 24'h010101, 1'b1, 1'b0, 2'd1, 1'b0);
        applyStimulus("maxAgain",     0, 24'h000000, 2'd2, 0, 2'd0, 0, 2'd0, 24'h010203, 1'b0, 1'b1, 2'd1, 1'b0);
        applyStimulus("zeroFallback", 0, 24'h000000, 2'd3, 1, 2'd1, 0, 2'd0, 24'h000000, 1'b0, 1'b0, 2'd1, 1'b1);
        applyStimulus("errCleared",   0, 24'h000000, 2'd3, 0, 2'd0, 0, 2'd0, 24'h000000, 1'b0, 1'b0, 2'd1, 1'b0);
        applyStimulus("maxReject",    0, 24'h000000, 2'd2, 0, 2'd0, 0, 2'd0, 24'h000000, 1'b0, 1'b0, 2'd1, 1'b1);
        applyStimulus("rejectOnce",   0, 24'h000000, 2'd3, 0, 2'd0, 0, 2'd0, 24'h000000, 1'b0, 1'b0, 2'd1, 1'b0);
        applyStimulus("clampStore",   0, 24'h0000AF, 2'd2, 1, 2'd2, 1, 2'd2, 24'h000099, 1'b0, 1'b1, 2'd2, 1'b0);
        applyStimulus("badActSel",    0, 24'h000000, 2'd3, 0, 2'd0, 1, 2'd3, 24'h000099, 1'b0, 1'b1, 2'd2, 1'b1);
        applyStimulus("badWrSel",     0, 24'h555555, 2'd3, 1, 2'd3, 0, 2'd0, 24'h000099, 1'b0, 1'b1, 2'd2, 1'b1);
        applyStimulus("idxErrOnce",   0, 24'h000000, 2'd3, 0, 2'd0, 0, 2'd0, 24'h000099, 1'b0, 1'b1, 2'd2, 1'b0);
        applyStimulus("storeActSame", 0, 24'h900009, 2'd1, 1, 2'd0, 1, 2'd0, 24'h100001, 1'b1, 1'b0, 2'd0, 1'b0);
        applyStimulus("carryRestore", 0, 24'h000050, 2'd3, 1, 2'd0, 0, 2'd0, 24'h000010, 1'b1, 1'b0, 2'd0, 1'b0);
        applyStimulus("toSingle",     0, 24'h000000, 2'd0, 0, 2'd0, 0, 2'd0, 24'h000000, 1'b0, 1'b0, 2'd0, 1'b0);
        applyStimulus("twoErrors",    0, 24'h000000, 2'd2, 1, 2'd3, 1, 2'd1, 24'h000000, 1'b0, 1'b0, 2'd1, 1'b1);
        applyStimulus("twoErrOnce",   0, 24'h000000, 2'd3, 0, 2'd0, 0, 2'd0, 24'h000000, 1'b0, 1'b0, 2'd1, 1'b0);
        applyStimulus("maxSlot0",     0, 24'h000000, 2'd2, 0, 2'd0, 1, 2'd0, 24'h000050, 1'b0, 1'b1, 2'd0, 1'b0);
        applyStimulus("resetMidMax",  1, 24'h000777, 2'd2, 1, 2'd0, 1, 2'd1, 24'h000000, 1'b0, 1'b0, 2'd0, 1'b0);
        applyStimulus("slot2Cleared", 0, 24'h000000, 2'd1, 0, 2'd0, 1, 2'd2, 24'h000000, 1'b1, 1'b0, 2'd2, 1'b0);
        applyStimulus("slot0Cleared", 0, 24'h000000, 2'd2, 0, 2'd0, 1, 2'd0, 24'h000000, 1'b1, 1'b0, 2'd0, 1'b1);
        applyStimulus("finalIdle",    0, 24'h000000, 2'd3, 0, 2'd0, 0, 2'd0, 24'h000000, 1'b1, 1'b0, 2'd0, 1'b0);

        for (int i = 0; i < 10 && expQ.size() > 0; i++) @(posedge clock);
        #2;
        if (expQ.size() > 0) begin
            checks++;
            $display("[TB] FAIL drain: got %0d pending responses want 0", expQ.size());
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
